fp_add_normalizer: RTL and testbench
====================================

Name: fp_add_normalizer

Overview:
- Post-addition normalization stage of the IEEE-754 single-precision floating-point adder.
- Takes the 25-bit raw mantissa sum (carry, hidden bit, 23 fraction bits) and the larger operand exponent.
- Produces a normalized 8-bit exponent and 23-bit fraction, registered on the clock.
- The exponent adjust adder is either ripple or carry-lookahead, selectable by parameter; results are bit-identical.

Parameters:
- USE_CLA, default 0: 0 = ripple exponent adjust adder; 1 = 4-bit-group carry-lookahead exponent adder/subtractor.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- exp_max  input  8  biased exponent of the larger operand
- fraction_25  input  25  raw mantissa sum:
  - [24] carry-out
  - [23] hidden bit
  - [22:0] fraction
- exp_out  output  8  normalized biased exponent (registered)
- fraction_out  output  23  normalized fraction without hidden bit (registered)

Behaviour:
- Reset: while rst_n = 0, exp_out = 0 and fraction_out = 0, asynchronously. Release takes effect on the next rising clk.
- Latency: 1 cycle. Inputs are sampled at rising clk and results appear after that edge. There is no handshake; a new input is accepted every cycle.
- Combinational core, with lz = count of leading zeros in fraction_25[23:0] (0..24):
  - Carry case, fraction_25[24] = 1: right shift by 1 (truncate, no rounding). fraction_out = fraction_25[23:1]; exp_out = exp_max + 1.
  - Already normalized, [24] = 0 and [23] = 1: fraction_out = fraction_25[22:0]; exp_out = exp_max.
  - Left-normalize, [24] = 0, [23] = 0, some bit in [22:0] set: shift fraction_25[23:0] left by lz and zero-fill the LSBs. fraction_out = shifted[22:0]; exp_out = exp_max - lz.
- Zero result: fraction_25 = 0 gives exp_out = 0 and fraction_out = 0.
- Underflow: in the left-normalize case, if lz >= exp_max, flush to zero (exp_out = 0, fraction_out = 0). No denormal generation.
- Overflow: in the carry case, if exp_max + 1 >= 255, output infinity (exp_out = 255, fraction_out = 0).
- exp_max = 255 input (Inf/NaN operand) is out of scope for this stage; output = infinity encoding as above for the carry case, otherwise the normal rules apply.
- Implementation structure:
  - Priority leading-zero counter over 24 bits.
  - 5-bit-control barrel left shifter.
  - 9-bit exponent adder/subtractor: ripple when USE_CLA = 0, CLA when USE_CLA = 1.
  - Output register.
- Both USE_CLA settings must produce identical outputs for all inputs.

Test Plan:
- Reset asserted mid-operation with non-zero outputs -> exp_out and fraction_out go to 0 immediately, without waiting for clk; the first edge after release loads the current inputs.
- Carry cases (shift right by 1):
  - exp_max = 25, fraction_25 = 25'b1110111110010110111110010 -> after 1 clk: exp_out = 26, fraction_out = 23'h6F96F9.
  - exp_max = 125, fraction_25 = 25'b1001101001100110011001101 -> exp_out = 126, fraction_out = 23'h1A6666 (LSB truncated).
- Already-normalized and 1-bit left shift:
  - exp_max = 25, fraction_25 = 25'b0110111110010110111110010 -> exp_out = 25, fraction_out = 23'h5F2DF2.
  - exp_max = 25, fraction_25 = 25'b0010111110010110111110010 -> exp_out = 24, fraction_out = 23'h3E5BE4.
- Multi-bit left shift: exp_max = 125, fraction_25 = 25'b0000111110010110111110010 -> exp_out = 122, fraction_out = 23'h796F90.
- Boundaries:
  - fraction_25 = 0 with exp_max = 100 -> exp_out = 0, fraction_out = 0.
  - exp_max = 254, fraction_25 = 25'h1000000 -> exp_out = 255, fraction_out = 0.
  - exp_max = 3, fraction_25 = 25'h000001 (lz = 23) -> exp_out = 0, fraction_out = 0.
- Equivalence: instantiate with USE_CLA = 0 and USE_CLA = 1 side by side and drive all of the above plus 10k random vectors -> outputs match every cycle.

Source files
------------

// File: rtl/fp_add_normalizer.sv
// Post-addition normalization for a single-precision FP adder: leading-zero
// count, barrel left shift, exponent adjust and output register (1-cycle latency).
module fp_add_normalizer #(
    parameter int USE_CLA = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  exp_max,
    input  logic [24:0] fraction_25,
    output logic [7:0]  exp_out,
    output logic [22:0] fraction_out
);

    logic        is_carry;
    logic        is_zero;
    logic [4:0]  lz;
    logic [22:0] shifted;
    logic [8:0]  add_a;
    logic [8:0]  add_b;
    logic [8:0]  add_b_op;
    logic        add_cin;
    logic [8:0]  gen;
    logic [8:0]  prop;
    logic [8:0]  carry;
    logic [8:0]  sum;
    logic        overflow;
    logic        underflow;
    logic [7:0]  exp_next;
    logic [22:0] frac_next;
    logic [7:0]  exp_reg;
    logic [22:0] frac_reg;

    assign is_carry = fraction_25[24];
    assign is_zero  = (fraction_25 == 25'd0);

    // Priority encoder: the highest set bit wins since it is visited last.
    always_comb begin
        lz = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (fraction_25[i]) begin
                lz = 5'(23 - i);
            end
        end
    end

    // Shifting only [22:0] is enough: the leading one lands on bit 23, which
    // is the hidden bit and gets dropped anyway.
    logic [22:0] sh_stage [0:5];
    assign sh_stage[0] = fraction_25[22:0];
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_shift
            assign sh_stage[gi+1] = lz[gi] ? (sh_stage[gi] << (1 << gi)) : sh_stage[gi];
        end
    endgenerate
    assign shifted = sh_stage[5];

    // Carry case adds 1; every other case subtracts lz (lz = 0 when normalized).
    assign add_a    = {1'b0, exp_max};
    assign add_b    = is_carry ? 9'd1 : {4'd0, lz};
    assign add_cin  = ~is_carry;
    assign add_b_op = is_carry ? add_b : ~add_b;

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_gp
            assign gen[gi]  = add_a[gi] & add_b_op[gi];
            assign prop[gi] = add_a[gi] ^ add_b_op[gi];
            assign sum[gi]  = prop[gi] ^ carry[gi];
        end

        if (USE_CLA != 0) begin : g_cla
            // Lookahead inside each 4-bit group, group carries chained.
            always_comb begin
                logic [8:0] cy;
                logic       run_c;
                logic       run_p;
                cy    = '0;
                run_c = 1'b0;
                run_p = 1'b0;
                cy[0] = add_cin;
                for (int k = 0; k < 8; k++) begin
                    run_c = gen[k];
                    run_p = prop[k];
                    for (int m = k - 1; m >= (k / 4) * 4; m--) begin
                        run_c = run_c | (run_p & gen[m]);
                        run_p = run_p & prop[m];
                    end
                    cy[k+1] = run_c | (run_p & cy[(k / 4) * 4]);
                end
                carry = cy;
            end
        end else begin : g_ripple
            always_comb begin
                logic [8:0] cy;
                cy    = '0;
                cy[0] = add_cin;
                for (int k = 0; k < 8; k++) begin
                    cy[k+1] = gen[k] | (prop[k] & cy[k]);
                end
                carry = cy;
            end
        end
    endgenerate

    // exp_max + 1 >= 255; and for subtraction a negative or zero difference.
    assign overflow  = sum[8] | (&sum[7:0]);
    assign underflow = sum[8] | (sum == 9'd0);

    always_comb begin
        exp_next  = sum[7:0];
        frac_next = shifted;
        if (is_zero) begin
            exp_next  = 8'd0;
            frac_next = 23'd0;
        end else if (is_carry) begin
            if (overflow) begin
                exp_next  = 8'hFF;
                frac_next = 23'd0;
            end else begin
                frac_next = fraction_25[23:1];
            end
        end else if (fraction_25[23]) begin
            exp_next  = exp_max;
            frac_next = fraction_25[22:0];
        end else if (underflow) begin
            exp_next  = 8'd0;
            frac_next = 23'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_reg  <= 8'd0;
            frac_reg <= 23'd0;
        end else begin
            exp_reg  <= exp_next;
            frac_reg <= frac_next;
        end
    end

    assign exp_out      = exp_reg;
    assign fraction_out = frac_reg;

endmodule

// File: tb/tb_fp_add_normalizer.sv
// Directed vector table plus reset sequence and random cross-check of the
// ripple and CLA builds of fp_add_normalizer against a behavioural model.
module tb_fp_add_normalizer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  exp_max;
    logic [24:0] fraction_25;
    logic [7:0]  exp_r;
    logic [22:0] frac_r;
    logic [7:0]  exp_c;
    logic [22:0] frac_c;

    int checks;
    int failures;

    typedef struct {
        logic [7:0]  e;
        logic [24:0] f;
        logic [7:0]  ee;
        logic [22:0] ef;
    } vec_t;

    vec_t vecs [0:17];

    fp_add_normalizer #(.USE_CLA(0)) dut_ripple (
        .clk          (clk),
        .rst_n        (rst_n),
        .exp_max      (exp_max),
        .fraction_25  (fraction_25),
        .exp_out      (exp_r),
        .fraction_out (frac_r)
    );

    fp_add_normalizer #(.USE_CLA(1)) dut_cla (
        .clk          (clk),
        .rst_n        (rst_n),
        .exp_max      (exp_max),
        .fraction_25  (fraction_25),
        .exp_out      (exp_c),
        .fraction_out (frac_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference: normalize with a shift loop, then apply the limits.
    function automatic logic [30:0] model(input logic [7:0] e, input logic [24:0] f);
        logic [23:0] m;
        int          n;
        if (f == 25'd0) return 31'd0;
        if (f[24]) begin
            if (int'(e) + 1 >= 255) return {8'hFF, 23'd0};
            return {e + 8'd1, f[23:1]};
        end
        m = f[23:0];
        n = 0;
        while (!m[23]) begin
            m = m << 1;
            n++;
        end
        if (n > 0 && n >= int'(e)) return 31'd0;
        return {8'(int'(e) - n), m[22:0]};
    endfunction

    task automatic check(input string name, input logic [7:0] ge, input logic [22:0] gf,
                         input logic [7:0] xe, input logic [22:0] xf);
        checks++;
        if (ge !== xe || gf !== xf) begin
            failures++;
            $display("FAIL %s: got exp=%0d frac=%h, expected exp=%0d frac=%h", name, ge, gf, xe, xf);
        end
    endtask

    task automatic check_both(input string name, input logic [7:0] xe, input logic [22:0] xf);
        check({name, "/ripple"}, exp_r, frac_r, xe, xf);
        check({name, "/cla"}, exp_c, frac_c, xe, xf);
    endtask

    task automatic apply(input logic [7:0] e, input logic [24:0] f);
        @(negedge clk);
        exp_max     = e;
        fraction_25 = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0]  = '{8'd25,  25'b1110111110010110111110010, 8'd26,  23'h6F96F9};
        vecs[1]  = '{8'd125, 25'b1001101001100110011001101, 8'd126, 23'h1A6666};
        vecs[2]  = '{8'd25,  25'b0110111110010110111110010, 8'd25,  23'h5F2DF2};
        vecs[3]  = '{8'd25,  25'b0010111110010110111110010, 8'd24,  23'h3E5BE4};
        vecs[4]  = '{8'd125, 25'b0000111110010110111110010, 8'd122, 23'h796F90};
        vecs[5]  = '{8'd100, 25'h0000000, 8'd0,   23'h000000};
        vecs[6]  = '{8'd254, 25'h1000000, 8'd255, 23'h000000};
        vecs[7]  = '{8'd3,   25'h0000001, 8'd0,   23'h000000};
        vecs[8]  = '{8'd253, 25'h1000000, 8'd254, 23'h000000};
        vecs[9]  = '{8'd255, 25'h1800000, 8'd255, 23'h000000};
        vecs[10] = '{8'd255, 25'h0800001, 8'd255, 23'h000001};
        vecs[11] = '{8'd0,   25'h0812345, 8'd0,   23'h012345};
        vecs[12] = '{8'd1,   25'h0400000, 8'd0,   23'h000000};
        vecs[13] = '{8'd2,   25'h0400000, 8'd1,   23'h000000};
        vecs[14] = '{8'd24,  25'h0000001, 8'd1,   23'h000000};
        vecs[15] = '{8'd200, 25'h0000003, 8'd178, 23'h400000};
        vecs[16] = '{8'd23,  25'h0000001, 8'd0,   23'h000000};
        vecs[17] = '{8'd17,  25'h1FFFFFF, 8'd18,  23'h7FFFFF};

        rst_n       = 1'b0;
        exp_max     = 8'd0;
        fraction_25 = 25'd0;
        repeat (2) @(posedge clk);
        #1;
        check_both("reset_state", 8'd0, 23'd0);

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            apply(vecs[i].e, vecs[i].f);
            $display("vec %0d: exp_max=%0d frac25=%h -> exp=%0d frac=%h (want %0d %h)",
                     i, vecs[i].e, vecs[i].f, exp_r, frac_r, vecs[i].ee, vecs[i].ef);
            check_both($sformatf("vec%0d", i), vecs[i].ee, vecs[i].ef);
        end

        // Asynchronous reset mid-cycle, then release and load the current inputs.
        apply(8'd25, 25'b1110111110010110111110010);
        check_both("pre_reset", 8'd26, 23'h6F96F9);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: exp=%0d frac=%h", exp_r, frac_r);
        check_both("async_reset", 8'd0, 23'd0);
        @(negedge clk);
        exp_max     = 8'd125;
        fraction_25 = 25'b0000111110010110111110010;
        rst_n       = 1'b1;
        #1;
        check_both("released_before_edge", 8'd0, 23'd0);
        @(posedge clk);
        #1;
        $display("after release: exp=%0d frac=%h", exp_r, frac_r);
        check_both("first_edge_after_release", 8'd122, 23'h796F90);

        for (int i = 0; i < 10000; i++) begin
            logic [7:0]  re;
            logic [24:0] rf;
            logic [30:0] exp_v;
            re    = (i % 4 == 0) ? 8'($urandom_range(0, 30)) : 8'($urandom_range(0, 255));
            rf    = 25'($urandom) >> $urandom_range(0, 25);
            exp_v = model(re, rf);
            apply(re, rf);
            check_both($sformatf("rand%0d", i), exp_v[30:23], exp_v[22:0]);
            checks++;
            if (exp_r !== exp_c || frac_r !== frac_c) begin
                failures++;
                $display("FAIL equiv%0d: ripple %0d/%h, cla %0d/%h", i, exp_r, frac_r, exp_c, frac_c);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
